// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- runtime-configurable UART receiver.
//
// Receives 5..DATA_WIDTH data bits, an optional parity bit (none/even/odd/
// mark/space) and one or two stop bits. Each bit is decided by a 3-sample
// majority vote around mid-bit. Finished frames go to a valid/ready holding
// register. A break (all-zero frame including the first stop bit) is reported
// as a pulse and is not delivered.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_tick              oversample tick, OVERSAMPLE pulses per bit time
//   i_data_bits         data length (out-of-range -> DATA_WIDTH)
//   i_parity_mode       0 none, 1 even, 2 odd, 3 mark, 4 space (5-7 -> none)
//   i_stop2             1 = two stop bits
//   i_RX                asynchronous serial line, idle high
//   o_data/o_valid      held word, right-justified / holding register full
//   i_ready             consumer handshake
//   o_parity_err        parity mismatch for the held word
//   o_frame_err         a stop bit of the held word sampled 0
//   o_break             one-cycle break pulse
//   o_overrun           sticky: a frame was dropped, cleared by i_error_rst
module uart_rx_cfg #(
   parameter int DATA_WIDTH  = 8,
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_tick,
   input  logic [3:0]            i_data_bits,
   input  logic [2:0]            i_parity_mode,
   input  logic                  i_stop2,
   input  logic                  i_RX,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_parity_err,
   output logic                  o_frame_err,
   output logic                  o_break,
   output logic                  o_overrun,
   input  logic                  i_error_rst
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   // Tick indices within a bit: two early samples, then the decision sample.
   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

   localparam logic [2:0] PM_NONE  = 3'd0;
   localparam logic [2:0] PM_EVEN  = 3'd1;
   localparam logic [2:0] PM_ODD   = 3'd2;
   localparam logic [2:0] PM_MARK  = 3'd3;
   localparam logic [2:0] PM_SPACE = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BRK_WAIT
   } state_t;

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic parity_expect(input logic [DATA_WIDTH-1:0] d,
                                          input logic [2:0] mode);
      logic p;
      case (mode)
         PM_EVEN:  p = ^d;
         PM_ODD:   p = ~(^d);
         PM_MARK:  p = 1'b1;
         PM_SPACE: p = 1'b0;
         default:  p = 1'b0;
      endcase
      return p;
   endfunction

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   rx_s;
   logic                   rx_prev_r;
   state_t                 state_r;
   logic [TW-1:0]          tick_cnt_r;
   logic [BW-1:0]          bit_cnt_r;
   logic [BW-1:0]          len_r;
   logic [2:0]             mode_r;
   logic                   stop2_r;
   logic [DATA_WIDTH-1:0]  shift_r;
   logic                   s0_r, s1_r;
   logic                   par_bit_r;
   logic                   perr_r, ferr_r;

   logic [3:0]             len_s;
   logic [2:0]             mode_s;
   logic                   vote_s, bit_tick_s, dec_s, break_s, done_s;
   logic [DATA_WIDTH-1:0]  align_s;

   assign rx_s = sync_r[SYNC_STAGES-1];

   // Normalise out-of-range configuration inputs before they are latched.
   always_comb begin
      if ((i_data_bits < 4'd5) || (i_data_bits > 4'(DATA_WIDTH))) begin
         len_s = 4'(DATA_WIDTH);
      end else begin
         len_s = i_data_bits;
      end
      if (i_parity_mode > PM_SPACE) begin
         mode_s = PM_NONE;
      end else begin
         mode_s = i_parity_mode;
      end
   end

   // Per-tick decode: bit decision strobe, right-justified word, break and frame completion.
   always_comb begin
      vote_s     = vote3(s0_r, s1_r, rx_s);
      bit_tick_s = i_tick && (state_r inside {ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2});
      dec_s      = bit_tick_s && (tick_cnt_r == T_DEC);
      // Bits enter at the MSB, so a short word sits at the top until realigned.
      align_s    = shift_r >> (BW'(DATA_WIDTH) - len_r);
      break_s    = dec_s && (state_r == ST_STOP1) && !vote_s && (shift_r == '0) &&
                   ((mode_r == PM_NONE) || !par_bit_r);
      done_s     = dec_s && (((state_r == ST_STOP1) && !stop2_r && !break_s) ||
                             (state_r == ST_STOP2));
   end

   // Input synchroniser for the asynchronous line, idle-high on reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sync_r <= '1;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], i_RX};
      end
   end

   // Receive FSM, bit sampling, and the valid/ready holding register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         rx_prev_r    <= 1'b1;
         tick_cnt_r   <= '0;
         bit_cnt_r    <= '0;
         len_r        <= '0;
         mode_r       <= PM_NONE;
         stop2_r      <= 1'b0;
         shift_r      <= '0;
         s0_r         <= 1'b1;
         s1_r         <= 1'b1;
         par_bit_r    <= 1'b0;
         perr_r       <= 1'b0;
         ferr_r       <= 1'b0;
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_parity_err <= 1'b0;
         o_frame_err  <= 1'b0;
         o_break      <= 1'b0;
         o_overrun    <= 1'b0;
      end else begin
         rx_prev_r <= rx_s;
         o_break   <= 1'b0;

         if (bit_tick_s) begin
            tick_cnt_r <= (tick_cnt_r == T_LAST) ? '0 : tick_cnt_r + TW'(1);
            if (tick_cnt_r == T_S0) s0_r <= rx_s;
            if (tick_cnt_r == T_S1) s1_r <= rx_s;
         end

         case (state_r)
            ST_IDLE: begin
               // Edge detect runs every cycle, independent of i_tick.
               if (!rx_s && rx_prev_r) begin
                  tick_cnt_r <= '0;
                  bit_cnt_r  <= '0;
                  len_r      <= BW'(len_s);
                  mode_r     <= mode_s;
                  stop2_r    <= i_stop2;
                  shift_r    <= '0;
                  perr_r     <= 1'b0;
                  ferr_r     <= 1'b0;
                  par_bit_r  <= 1'b0;
                  state_r    <= ST_START;
               end
            end
            ST_START: begin
               if (dec_s) state_r <= vote_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
               if (dec_s) begin
                  shift_r <= {vote_s, shift_r[DATA_WIDTH-1:1]};
                  if (bit_cnt_r == (len_r - BW'(1))) begin
                     bit_cnt_r <= '0;
                     state_r   <= (mode_r != PM_NONE) ? ST_PARITY : ST_STOP1;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (dec_s) begin
                  par_bit_r <= vote_s;
                  perr_r    <= (vote_s != parity_expect(align_s, mode_r));
                  state_r   <= ST_STOP1;
               end
            end
            ST_STOP1: begin
               if (dec_s) begin
                  if (break_s) begin
                     o_break <= 1'b1;
                     state_r <= ST_BRK_WAIT;
                  end else if (stop2_r) begin
                     ferr_r  <= ferr_r | ~vote_s;
                     state_r <= ST_STOP2;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end
            end
            ST_STOP2: begin
               if (dec_s) state_r <= ST_IDLE;
            end
            ST_BRK_WAIT: begin
               if (i_tick && rx_s) state_r <= ST_IDLE;
            end
            default: state_r <= ST_IDLE;
         endcase

         // Clear first so that a same-cycle overrun below takes precedence.
         if (i_error_rst) o_overrun <= 1'b0;

         if (done_s) begin
            if (!o_valid || i_ready) begin
               o_data       <= align_s;
               o_parity_err <= perr_r;
               o_frame_err  <= ferr_r | ~vote_s;
               o_valid      <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: expected words are queued when a frame
// is sent and compared when the DUT hands the word over (o_valid && i_ready).
module tb_uart_rx_cfg;

   localparam int TICK_DIV = 13;
   localparam int BIT_CLKS = 16 * TICK_DIV;

   logic       clk;
   logic       i_rst;
   logic       i_tick;
   logic [3:0] i_data_bits;
   logic [2:0] i_parity_mode;
   logic       i_stop2;
   logic       i_RX;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_parity_err;
   logic       o_frame_err;
   logic       o_break;
   logic       o_overrun;
   logic       i_error_rst;

   int checks   = 0;
   int failures = 0;
   int brk_cnt  = 0;
   int brk0;
   int tmr_cnt;
   bit tmr_hit;

   // {data, parity_err, frame_err}
   logic [9:0] sb_q[$];

   uart_rx_cfg #(.DATA_WIDTH(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_tick        (i_tick),
      .i_data_bits   (i_data_bits),
      .i_parity_mode (i_parity_mode),
      .i_stop2       (i_stop2),
      .i_RX          (i_RX),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_parity_err  (o_parity_err),
      .o_frame_err   (o_frame_err),
      .o_break       (o_break),
      .o_overrun     (o_overrun),
      .i_error_rst   (i_error_rst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversample tick: one cycle in every TICK_DIV, driven on the falling edge.
   initial begin
      i_tick = 1'b0;
      forever begin
         repeat (TICK_DIV - 1) @(negedge clk);
         i_tick = 1'b1;
         @(negedge clk);
         i_tick = 1'b0;
      end
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      i_RX = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [8:0] data, input logic [3:0] nbits,
                             input logic [2:0] pm, input logic st2,
                             input logic par_flip, input logic stop_v);
      logic [8:0] dm;
      logic       p;
      i_data_bits   = nbits;
      i_parity_mode = pm;
      i_stop2       = st2;
      dm = data & ((9'd1 << nbits) - 9'd1);
      case (pm)
         3'd1:    p = ^dm;
         3'd2:    p = ~(^dm);
         3'd3:    p = 1'b1;
         default: p = 1'b0;
      endcase
      drive_bit(1'b0);
      for (int i = 0; i < int'(nbits); i++) drive_bit(data[i]);
      if (pm >= 3'd1 && pm <= 3'd4) drive_bit(p ^ par_flip);
      drive_bit(stop_v);
      if (st2) drive_bit(1'b1);
      i_RX = 1'b1;
   endtask

   // Scoreboard consumer: sampled after the falling-edge drives have settled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!i_rst) begin
            if (o_break) brk_cnt++;
            if (o_valid && i_ready) begin
               if (sb_q.size() == 0) begin
                  chk_eq("sb_unexpected_word", sb_q.size(), 1);
               end else begin
                  chk_eq("sb_word", {o_data, o_parity_err, o_frame_err}, sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      i_rst = 1'b1; i_RX = 1'b1; i_ready = 1'b0; i_error_rst = 1'b0;
      i_data_bits = 4'd8; i_parity_mode = 3'd0; i_stop2 = 1'b0;
      repeat (5) @(negedge clk);
      chk_eq("rst_data", o_data, 0);
      chk_eq("rst_valid", o_valid, 0);
      chk_eq("rst_perr", o_parity_err, 0);
      chk_eq("rst_ferr", o_frame_err, 0);
      chk_eq("rst_break", o_break, 0);
      chk_eq("rst_overrun", o_overrun, 0);
      i_rst = 1'b0;
      repeat (20) @(negedge clk);

      // 8N1 single word, consumer pulses ready once.
      sb_q.push_back({8'hA5, 1'b0, 1'b0});
      send_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk_eq("t1_valid", o_valid, 1);
      chk_eq("t1_data", o_data, 8'hA5);
      chk_eq("t1_perr", o_parity_err, 0);
      chk_eq("t1_ferr", o_frame_err, 0);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk_eq("t1_valid_cleared", o_valid, 0);

      // 7E2, good then bad parity.
      i_ready = 1'b1;
      sb_q.push_back({8'h35, 1'b0, 1'b0});
      send_frame(9'h035, 4'd7, 3'd1, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1);
      sb_q.push_back({8'h35, 1'b1, 1'b0});
      send_frame(9'h035, 4'd7, 3'd1, 1'b1, 1'b1, 1'b1);
      drive_bit(1'b1);

      // Short glitch must be a false start; then a framing fault.
      i_RX = 1'b0;
      repeat (4 * TICK_DIV) @(negedge clk);
      i_RX = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk_eq("t3_glitch_valid", o_valid, 0);
      chk_eq("t3_glitch_sb", sb_q.size(), 0);
      sb_q.push_back({8'h55, 1'b0, 1'b1});
      send_frame(9'h055, 4'd8, 3'd0, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b1);

      // Break, then recovery.
      brk0 = brk_cnt;
      i_RX = 1'b0;
      repeat (12 * BIT_CLKS) @(negedge clk);
      i_RX = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk_eq("t4_break_pulses", brk_cnt - brk0, 1);
      chk_eq("t4_break_valid", o_valid, 0);
      sb_q.push_back({8'h3C, 1'b0, 1'b0});
      send_frame(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
      drive_bit(1'b1);
      chk_eq("t4_drained", sb_q.size(), 0);

      // Overrun: two back-to-back frames with no consumer.
      i_ready = 1'b0;
      sb_q.push_back({8'h11, 1'b0, 1'b0});
      send_frame(9'h011, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
      send_frame(9'h022, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk_eq("t5_valid", o_valid, 1);
      chk_eq("t5_data", o_data, 8'h11);
      chk_eq("t5_overrun_set", o_overrun, 1);
      i_error_rst = 1'b1;
      @(negedge clk);
      i_error_rst = 1'b0;
      chk_eq("t5_overrun_clr", o_overrun, 0);
      repeat (20) @(negedge clk);

      // Handshake lands on the completion cycle: new word loads, no overrun.
      // Edge reaches the FSM on the 3rd clock; ticks count from the 4th;
      // the 8N1 stop decision is the 154th counted tick.
      sb_q.push_back({8'h33, 1'b0, 1'b0});
      tmr_cnt = 0;
      tmr_hit = 1'b0;
      fork
         send_frame(9'h033, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
         begin
            for (int k = 1; k < 4000 && !tmr_hit; k++) begin
               @(negedge clk);
               #1;
               if (k >= 3 && i_tick) tmr_cnt++;
               if (tmr_cnt == 154) begin
                  i_ready = 1'b1;
                  @(negedge clk);
                  #1;
                  i_ready = 1'b0;
                  tmr_hit = 1'b1;
               end
            end
            chk_eq("t5_ready_timer", tmr_hit, 1);
         end
      join
      repeat (20) @(negedge clk);
      chk_eq("t5_same_cycle_valid", o_valid, 1);
      chk_eq("t5_same_cycle_data", o_data, 8'h33);
      chk_eq("t5_same_cycle_overrun", o_overrun, 0);

      // Reset during data bit 3 of 0xF0 drops the held word and the frame.
      fork
         send_frame(9'h0F0, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);
         begin
            repeat (4 * BIT_CLKS + 170) @(negedge clk);
            i_rst = 1'b1;
            sb_q.delete();
            @(negedge clk);
            chk_eq("t6_rst_data", o_data, 0);
            chk_eq("t6_rst_valid", o_valid, 0);
            chk_eq("t6_rst_perr", o_parity_err, 0);
            chk_eq("t6_rst_ferr", o_frame_err, 0);
            chk_eq("t6_rst_overrun", o_overrun, 0);
            i_rst = 1'b0;
         end
      join
      drive_bit(1'b1);
      chk_eq("t6_no_output", o_valid, 0);
      i_ready = 1'b1;
      sb_q.push_back({8'h0F, 1'b0, 1'b0});
      send_frame(9'h00F, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1);

      for (int n = 0; n < 2000 && sb_q.size() != 0; n++) @(negedge clk);
      repeat (5) @(negedge clk);
      chk_eq("sb_drain", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Runtime-configurable UART receiver, the next generation of the receive path in the `uart` top. It is parametrised in maximum data width and oversampling ratio, and supports 5..DATA_WIDTH data bits, five parity modes and 1 or 2 stop bits. Line sampling uses a 3-sample majority vote. The block also detects break conditions. It takes the oversample tick from the existing fractional baud generator and delivers each frame through a valid/ready holding register that sits in front of the RX FIFO.

## Interface
- DATA_WIDTH, 8: maximum data bits per frame. Legal range 5..9.
- OVERSAMPLE, 16: ticks per bit. Must be even and ≥8.
- SYNC_STAGES, 2: depth of the RX input synchroniser.

- i_clk  in  1  single clock. All logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_tick  in  1  one-cycle pulse, OVERSAMPLE pulses per bit time.
- i_data_bits  in  4  data length. Values below 5 or above DATA_WIDTH are treated as DATA_WIDTH.
- i_parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space. Values 5-7 are treated as none.
- i_stop2  in  1  1 = two stop bits.
- i_RX  in  1  asynchronous serial line, idle high.
- o_data  out  DATA_WIDTH  received word, LSB-first, right-justified, unused upper bits 0.
- o_valid  out  1  o_data and its error flags are held valid.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_parity_err  out  1  parity mismatch for the held word.
- o_frame_err  out  1  a stop bit sampled 0 for the held word.
- o_break  out  1  one-cycle pulse when a break is detected.
- o_overrun  out  1  sticky. A completed frame was dropped because the holding register was full.
- i_error_rst  in  1  clears o_overrun.

## Operation
- **Synchroniser.** SYNC_STAGES flops. Reset value is all 1s.
- **Majority vote.** Within a bit, sample the synchronised line on ticks M-1, M and M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 samples. The bit decision occurs on tick M+1.
- **Counters.**
  - Tick counter: $clog2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1.
  - Bit counter: $clog2(DATA_WIDTH+1) bits.
- **IDLE.**
  - Wait for a 1→0 transition of the synchronised line.
  - On the transition: clear the tick counter, latch i_data_bits, i_parity_mode and i_stop2, then go to START.
  - Configuration changes mid-frame have no effect.
- **START.** At the vote decision:
  - vote = 1: false start, go to IDLE.
  - otherwise go to DATA.
- **DATA.**
  - Shift the voted bit in LSB-first.
  - After the latched length, go to PARITY if parity is enabled, else go to STOP.
- **PARITY.**
  - Expected bit: even = XOR of the data bits; odd = its complement; mark = 1; space = 0.
  - Mismatch sets the per-frame parity error.
- **STOP.**
  - Vote the first stop bit; a 0 sets the per-frame frame error.
  - If the latched i_stop2 is set, vote a second stop bit with the same check.
  - The frame completes at the decision of the last stop bit, then the FSM returns to IDLE. It does not wait for the end of the stop bit, which allows resync.
- **Break.** All data bits 0, parity bit 0 (when enabled) and the first stop bit 0 means a break:
  - pulse o_break;
  - do not deliver the frame;
  - go to BREAK_WAIT.
- **BREAK_WAIT.** Stay until the synchronised line is 1, then go to IDLE.
- **Holding register.** On frame completion:
  - If o_valid=0, or o_valid && i_ready in the same cycle: load o_data and the error flags, and set o_valid.
  - Else (o_valid && !i_ready): drop the new frame, keep the old word, and set o_overrun.
  - o_valid clears on handshake when no new frame completes in the same cycle.
- **o_overrun.**
  - Cleared by i_error_rst.
  - If i_error_rst and a new overrun occur in the same cycle, the set wins.

## Timing
- **Reset.**
  - FSM to IDLE; all counters 0; shift register 0.
  - Outputs: o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_break=0, o_overrun=0.
  - Reset mid-frame aborts the frame with no output.
- **Input latency.** A line edge reaches the FSM SYNC_STAGES cycles after i_RX changes.
- **Output latency.**
  - o_valid rises on the clock after the i_tick cycle of the last stop-bit decision.
  - o_break pulses on the clock after the break decision.
- **Flag alignment.** o_parity_err and o_frame_err change only when o_data loads.
- **Tick gating.** No state advances on cycles without i_tick, except the IDLE edge detect, which runs every cycle.
- **Throughput.** Back-to-back frames with zero idle between them are received without loss, provided the consumer asserts i_ready.

## Test plan
- **8N1 single word.** Bench tick every 13 clocks, send 0xA5 → o_valid=1, o_data=0xA5, both errors 0. i_ready pulse → o_valid=0 on the next clock.
- **7E2 with parity fault.** Send 0x35 with correct parity bit 0 → no error. Resend 0x35 with parity bit 1 → o_data=0x35, o_parity_err=1.
- **Glitch, then framing fault.**
  - Line low for 4 ticks, then high → no o_valid, FSM back in IDLE.
  - 8N1 0x55 with stop bit 0 → o_frame_err=1.
- **Break and recovery.** Line low for 12 bit times → exactly one o_break pulse and no o_valid. Line high, then send 0x3C → o_data=0x3C with no errors.
- **Overrun.**
  - Send 0x11 then 0x22 with i_ready=0 → o_data=0x11, o_overrun=1.
  - i_error_rst → o_overrun=0.
  - Frame completing in the same cycle as a handshake → new word loaded, o_overrun stays 0.
- **Reset mid-frame.** Assert i_rst during the DATA bit 3 of 0xF0 → all outputs 0 on the next clock. The next frame, 0x0F, is received correctly.
